// File: rtl/kernel_bram_loader.sv
// Streams a kernel-weight tensor into KERNEL_BRAM_NUM banks, filters interleaved
// round-robin, each bank holding whole filters back to back (channel, row, column).
module kernel_bram_loader #(
  parameter int KERNEL_FILTER_WIDTH       = 7,
  parameter int KERNEL_CHANNEL_WIDTH      = 7,
  parameter int KERNEL_ROW_WIDTH          = 2,
  parameter int KERNEL_COL_WIDTH          = 2,
  parameter int KERNEL_BRAM_NUM           = 4,
  parameter int KERNEL_BRAM_DEPTH         = 1152,
  parameter int KERNEL_BRAM_ADDRESS_WIDTH = $clog2(KERNEL_BRAM_DEPTH),
  parameter int DATA_WIDTH                = 16
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_start,
  input  logic [KERNEL_CHANNEL_WIDTH-1:0]      i_kernel_channel,
  input  logic [KERNEL_ROW_WIDTH-1:0]          i_kernel_row,
  input  logic [KERNEL_COL_WIDTH-1:0]          i_kernel_col,
  input  logic [KERNEL_FILTER_WIDTH-1:0]       i_kernel_start_filter,
  input  logic [KERNEL_FILTER_WIDTH-1:0]       i_kernel_end_filter,
  input  logic [DATA_WIDTH-1:0]                i_data,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  output logic [KERNEL_BRAM_NUM-1:0]           o_bram_we,
  output logic [KERNEL_BRAM_ADDRESS_WIDTH-1:0] o_bram_addr,
  output logic [DATA_WIDTH-1:0]                o_bram_data,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_error
);

  localparam int FW     = KERNEL_FILTER_WIDTH;
  localparam int AW     = KERNEL_BRAM_ADDRESS_WIDTH;
  localparam int S_W    = KERNEL_CHANNEL_WIDTH + KERNEL_ROW_WIDTH + KERNEL_COL_WIDTH;
  localparam int NF_W   = FW + 1;
  localparam int NEED_W = S_W + NF_W + 1;
  localparam int BANK_W = (KERNEL_BRAM_NUM > 1) ? $clog2(KERNEL_BRAM_NUM) : 1;

  typedef enum logic [1:0] {IDLE, CFG, LOAD, DONE} state_t;

  state_t                      state;
  logic [KERNEL_CHANNEL_WIDTH-1:0] cfg_c;
  logic [KERNEL_ROW_WIDTH-1:0] cfg_r;
  logic [KERNEL_COL_WIDTH-1:0] cfg_k;
  logic [FW-1:0]               cfg_start;
  logic [FW-1:0]               cfg_end;
  logic [S_W-1:0]              s_last;
  logic [FW-1:0]               filt_last;
  logic [FW-1:0]               filt_cnt;
  logic [S_W-1:0]              elem;
  logic [BANK_W-1:0]           bank;
  logic [AW-1:0]               addr;
  logic [AW-1:0]               base;

  logic [S_W-1:0]              s_val;
  logic [NF_W-1:0]             nf_val;
  logic [NEED_W-1:0]           need;
  logic                        cfg_err;

  // Configuration check; the division is by a constant bank count only.
  always_comb begin
    s_val   = S_W'(cfg_c) * S_W'(cfg_r) * S_W'(cfg_k);
    nf_val  = NF_W'(cfg_end) - NF_W'(cfg_start) + NF_W'(1);
    need    = ((NEED_W'(nf_val) + NEED_W'(KERNEL_BRAM_NUM - 1)) / NEED_W'(KERNEL_BRAM_NUM))
              * NEED_W'(s_val);
    cfg_err = (cfg_c == '0) || (cfg_r == '0) || (cfg_k == '0) ||
              (cfg_end < cfg_start) || (need > NEED_W'(KERNEL_BRAM_DEPTH));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      cfg_c       <= '0;
      cfg_r       <= '0;
      cfg_k       <= '0;
      cfg_start   <= '0;
      cfg_end     <= '0;
      s_last      <= '0;
      filt_last   <= '0;
      filt_cnt    <= '0;
      elem        <= '0;
      bank        <= '0;
      addr        <= '0;
      base        <= '0;
      o_ready     <= 1'b0;
      o_bram_we   <= '0;
      o_bram_addr <= '0;
      o_bram_data <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      o_bram_we <= '0;
      o_done    <= 1'b0;
      o_error   <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            cfg_c     <= i_kernel_channel;
            cfg_r     <= i_kernel_row;
            cfg_k     <= i_kernel_col;
            cfg_start <= i_kernel_start_filter;
            cfg_end   <= i_kernel_end_filter;
            o_busy    <= 1'b1;
            state     <= CFG;
          end
        end
        CFG: begin
          if (cfg_err) begin
            o_error <= 1'b1;
            o_busy  <= 1'b0;
            state   <= IDLE;
          end else begin
            s_last    <= s_val - S_W'(1);
            filt_last <= cfg_end - cfg_start;
            filt_cnt  <= '0;
            elem      <= '0;
            bank      <= '0;
            addr      <= '0;
            base      <= '0;
            o_ready   <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (i_valid) begin
            o_bram_we   <= KERNEL_BRAM_NUM'(1) << bank;
            o_bram_addr <= addr;
            o_bram_data <= i_data;
            if (elem == s_last) begin
              // End of a filter: next bank, or wrap to bank 0 on a fresh filter slot.
              elem     <= '0;
              filt_cnt <= filt_cnt + FW'(1);
              if (filt_cnt == filt_last) begin
                o_ready <= 1'b0;
                o_done  <= 1'b1;
                state   <= DONE;
              end
              if (bank == BANK_W'(KERNEL_BRAM_NUM - 1)) begin
                bank <= '0;
                base <= addr + AW'(1);
                addr <= addr + AW'(1);
              end else begin
                bank <= bank + BANK_W'(1);
                addr <= base;
              end
            end else begin
              elem <= elem + S_W'(1);
              addr <= addr + AW'(1);
            end
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
